sequence_display: RTL and testbench
===================================

// Module: sequence_display
// PURPOSE
//  Producer side of the sequence-check handshake: fetches the round's digits from sequence RAM,
//  presents them one at a time (hold, then blank gap), assembles the packed expected sequence
//  S_out, and pulses display_done. S_out and display_done feed sequenceCheck's S_in and
//  display_done; digit_out/digit_valid drive the hex display decoder.
// PARAMETERS
//  SHOW_CYCLES  25_000_000  clocks each digit is held with digit_valid=1 (>=1)
//  GAP_CYCLES   5_000_000   blank clocks after each digit, digit_valid=0 (>=1)
//  MAX_LVL      5           max digits per round; S_out width = 4*MAX_LVL
//  BASE_ADDR    5'd0        RAM address of digit 0
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-low
//  start         in   1   1-cycle request to display a round; ignored while busy=1
//  LVL           in   3   digits this round; latched on accepted start
//  RAM_data      in   4   sequence RAM read data, valid 1 clk after RAM_r
//  RAM_r         out  1   RAM read strobe, 1 clk per digit
//  RAM_addr      out  5   BASE_ADDR + digit index
//  digit_out     out  4   digit being shown (0 when not showing)
//  digit_valid   out  1   1 while digit_out is in its hold window
//  S_out         out  20  packed sequence; digit i at S_out[19-4i -: 4], unused digits 0
//  busy          out  1   1 from accepted start through the display_done cycle
//  display_done  out  1   1-cycle pulse after last gap
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE; all outputs 0; index, timer, latched LVL cleared.
//   Reset mid-round aborts immediately; no display_done is issued.
//  LVL clamp at latch: 0 -> 1, >MAX_LVL -> MAX_LVL. Later LVL changes are ignored.
//  FSM, one transition per clock:
//   IDLE   start=1 -> FETCH; latch n=clamp(LVL), index=0, clear S_out, busy=1.
//   FETCH  RAM_r=1, RAM_addr=BASE_ADDR+index (5-bit, wraps mod 32) -> WAIT.
//   WAIT   RAM_r=0; RAM_data now valid -> LATCH.
//   LATCH  digit_out<=RAM_data, S_out[19-4*index -:4]<=RAM_data, timer<=0 -> SHOW.
//   SHOW   digit_valid=1 exactly SHOW_CYCLES clocks -> GAP (digit_out<=0, timer<=0).
//   GAP    digit_valid=0 for GAP_CYCLES clocks; then index==n-1 -> DONE, else index++ -> FETCH.
//   DONE   display_done=1 and busy=1 for this one clock -> IDLE (busy=0 next).
//  Outputs are registered. Per-digit cost = 3 + SHOW_CYCLES + GAP_CYCLES clocks;
//   round = n*(3+SHOW+GAP)+1 clocks from start-accept edge to display_done.
//  S_out holds its last value in IDLE until the next accepted start; a start asserted in the
//   DONE cycle is ignored.
//  RAM_addr holds its last value outside FETCH; RAM_r is high in FETCH only.
//  Timer width $clog2(max(SHOW,GAP)+1); terminal count compare, no free-running wrap.
// STRUCTURE
//  Shared package (seq_pkg): FSM state encoding, DIGIT_W=4, MAX_LVL, ADDR_W=5, LVL clamp function.
//  One sub-module: display_timer (load/clear, enable, terminal-count compare against a
//   runtime limit, done flag); the FSM instantiates one and selects the SHOW or GAP limit.
// TESTING  (bench params SHOW_CYCLES=4, GAP_CYCLES=2; RAM model 1-clk latency, mem[0..4]=1,2,3,A,C)
//  1 LVL=5, start pulse -> RAM_addr 0..4 in order; digit_out 1,2,3,A,C each valid 4 clks;
//    S_out=20'h123AC; display_done single pulse 46 clks after start-accept edge.
//  2 LVL=2 -> S_out=20'h12000; only 2 RAM reads; display_done after 19 clks.
//  3 LVL=0 -> treated as 1 (S_out=20'h10000); LVL=7 -> treated as 5 (S_out=20'h123AC).
//  4 start re-pulsed and LVL changed mid-round -> no restart, sequence and timing of test 1 unchanged.
//  5 rst=0 during SHOW of digit 2 -> next clk all outputs 0, IDLE; no display_done; fresh start works.
//  6 BASE_ADDR=5'd30, LVL=4 -> RAM_addr 30,31,0,1 (wrap); S_out from those words in order.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence display block: digit/address widths,
// FSM state encoding and the round-length clamp.
package seq_pkg;

   localparam int DIGIT_W = 4;
   localparam int MAX_LVL = 5;
   localparam int ADDR_W  = 5;
   localparam int LVL_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_LATCH,
      ST_SHOW,
      ST_GAP,
      ST_DONE
   } state_t;

   // A round always shows at least one digit and never more than the
   // sequence register can hold.
   function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl,
                                                  input int               max_lvl);
      logic [LVL_W-1:0] res;
      if (lvl == '0)
         res = LVL_W'(1);
      else if (int'(lvl) > max_lvl)
         res = LVL_W'(max_lvl);
      else
         res = lvl;
      return res;
   endfunction

endpackage

// File: rtl/display_timer.sv
// Window timer for the digit hold and gap phases: counts enabled clocks from
// zero and flags the last clock of a window of i_limit clocks.
module display_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic [W-1:0] i_limit,
   output logic         o_done
);

   logic [W-1:0] r_cnt;
   logic         w_last;

   assign w_last = (r_cnt == i_limit - W'(1));
   assign o_done = i_enable && w_last;

   // Count enabled clocks; clear restarts a window, terminal count holds.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with <= so every flop samples pre-edge values.
      if (!rst)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable && !w_last)
         r_cnt <= r_cnt + W'(1);
   end

endmodule

// File: rtl/sequence_display.sv
// Producer side of the sequence-check handshake: reads the round's digits from
// sequence RAM, shows each for a hold window followed by a blank gap, builds
// the packed expected sequence and pulses display_done at the end.
module sequence_display
   import seq_pkg::*;
#(
   parameter int                SHOW_CYCLES = 25_000_000,
   parameter int                GAP_CYCLES  = 5_000_000,
   parameter int                MAX_LVL     = seq_pkg::MAX_LVL,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 5'd0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LVL_W-1:0]           LVL,
   input  logic [DIGIT_W-1:0]         RAM_data,
   output logic                       RAM_r,
   output logic [ADDR_W-1:0]          RAM_addr,
   output logic [DIGIT_W-1:0]         digit_out,
   output logic                       digit_valid,
   output logic [DIGIT_W*MAX_LVL-1:0] S_out,
   output logic                       busy,
   output logic                       display_done
);

   localparam int SEQ_W   = DIGIT_W * MAX_LVL;
   localparam int T_MAX   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TIMER_W = $clog2(T_MAX + 1);

   state_t               r_state;
   state_t               w_next;
   logic [LVL_W-1:0]     r_n;
   logic [LVL_W-1:0]     r_idx;
   logic [LVL_W-1:0]     w_idx_next;
   logic                 w_last_digit;

   logic                 w_tmr_clr;
   logic                 w_tmr_en;
   logic                 w_tmr_done;
   logic [TIMER_W-1:0]   w_limit;

   logic                 r_ram_r;
   logic [ADDR_W-1:0]    r_ram_addr;
   logic [DIGIT_W-1:0]   r_digit;
   logic                 r_valid;
   logic [SEQ_W-1:0]     r_s_out;
   logic                 r_busy;
   logic                 r_done;

   assign w_last_digit = (r_idx == r_n - LVL_W'(1));
   assign w_limit      = (r_state == ST_GAP) ? TIMER_W'(GAP_CYCLES) : TIMER_W'(SHOW_CYCLES);

   display_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_tmr_clr),
      .i_enable (w_tmr_en),
      .i_limit  (w_limit),
      .o_done   (w_tmr_done)
   );

   // Next-state, next digit index and timer control for the display sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      w_next     = r_state;
      w_idx_next = r_idx;
      w_tmr_clr  = 1'b0;
      w_tmr_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next     = ST_FETCH;
               w_idx_next = '0;
            end
         end
         ST_FETCH: w_next = ST_WAIT;
         ST_WAIT:  w_next = ST_LATCH;
         ST_LATCH: begin
            w_next    = ST_SHOW;
            w_tmr_clr = 1'b1;
         end
         ST_SHOW: begin
            w_tmr_en = 1'b1;
            if (w_tmr_done) begin
               w_next    = ST_GAP;
               w_tmr_clr = 1'b1;
            end
         end
         ST_GAP: begin
            w_tmr_en = 1'b1;
            if (w_tmr_done) begin
               w_tmr_clr = 1'b1;
               if (w_last_digit) begin
                  w_next = ST_DONE;
               end else begin
                  w_next     = ST_FETCH;
                  w_idx_next = r_idx + LVL_W'(1);
               end
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State, index and registered outputs; outputs follow the state being entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_n        <= '0;
         r_idx      <= '0;
         r_ram_r    <= 1'b0;
         r_ram_addr <= '0;
         r_digit    <= '0;
         r_valid    <= 1'b0;
         r_s_out    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_next;
         r_ram_r <= (w_next == ST_FETCH);
         r_valid <= (w_next == ST_SHOW);
         r_busy  <= (w_next != ST_IDLE);
         r_done  <= (w_next == ST_DONE);

         // Address wraps modulo 32 by construction of the 5-bit sum.
         if (w_next == ST_FETCH)
            r_ram_addr <= BASE_ADDR + ADDR_W'(w_idx_next);

         if (r_state == ST_IDLE && start) begin
            r_n     <= clamp_lvl(LVL, MAX_LVL);
            r_s_out <= '0;
         end

         if (r_state == ST_LATCH) begin
            r_digit <= RAM_data;
            r_s_out[(SEQ_W - 1) - DIGIT_W * int'(r_idx) -: DIGIT_W] <= RAM_data;
         end else if (r_state == ST_SHOW && w_tmr_done) begin
            r_digit <= '0;
         end
      end
   end

   assign RAM_r        = r_ram_r;
   assign RAM_addr     = r_ram_addr;
   assign digit_out    = r_digit;
   assign digit_valid  = r_valid;
   assign S_out        = r_s_out;
   assign busy         = r_busy;
   assign display_done = r_done;

endmodule

// File: tb/tb_sequence_display.sv
// Scoreboard bench for sequence_display. Two instances share stimulus: lane 0
// reads from address 0, lane 1 from address 30 (exercising the address wrap).
// Expected reads, digits and round results are queued when a start is issued
// and consumed by a monitor that samples on the falling clock edge.
module tb_sequence_display;

   localparam int SHOW  = 4;
   localparam int GAP   = 2;
   localparam int MAXL  = 5;
   localparam int LANES = 2;

   typedef struct {
      logic [19:0] s;
      int          lat;
   } round_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  lvl;

   logic [3:0]  ram_data  [LANES];
   logic        ram_r     [LANES];
   logic [4:0]  ram_addr  [LANES];
   logic [3:0]  digit_out [LANES];
   logic        dvalid    [LANES];
   logic [19:0] s_out     [LANES];
   logic        busy      [LANES];
   logic        done      [LANES];

   logic [3:0]  mem [32];
   logic [4:0]  base [LANES];

   logic [4:0]  q_addr  [LANES][$];
   logic [3:0]  q_dig   [LANES][$];
   round_t      q_round [LANES][$];

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        rst_q;
   logic        prev_valid [LANES];
   logic        prev_busy  [LANES];
   int          vcnt       [LANES];
   int          acc_cyc    [LANES];

   always #5 clk = ~clk;

   sequence_display #(
      .SHOW_CYCLES (SHOW),
      .GAP_CYCLES  (GAP),
      .MAX_LVL     (MAXL),
      .BASE_ADDR   (5'd0)
   ) dut0 (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .LVL          (lvl),
      .RAM_data     (ram_data[0]),
      .RAM_r        (ram_r[0]),
      .RAM_addr     (ram_addr[0]),
      .digit_out    (digit_out[0]),
      .digit_valid  (dvalid[0]),
      .S_out        (s_out[0]),
      .busy         (busy[0]),
      .display_done (done[0])
   );

   sequence_display #(
      .SHOW_CYCLES (SHOW),
      .GAP_CYCLES  (GAP),
      .MAX_LVL     (MAXL),
      .BASE_ADDR   (5'd30)
   ) dut1 (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .LVL          (lvl),
      .RAM_data     (ram_data[1]),
      .RAM_r        (ram_r[1]),
      .RAM_addr     (ram_addr[1]),
      .digit_out    (digit_out[1]),
      .digit_valid  (dvalid[1]),
      .S_out        (s_out[1]),
      .busy         (busy[1]),
      .display_done (done[1])
   );

   // Sequence RAM models: one clock of read latency, data held between reads.
   always @(posedge clk) begin
      for (int k = 0; k < LANES; k++)
         if (ram_r[k]) ram_data[k] <= mem[ram_addr[k]];
   end

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Reference: a round shows clamp(LVL) digits read from consecutive
   // addresses starting at the base, each costing 3+SHOW+GAP clocks.
   task automatic expect_round(input logic [2:0] l);
      int n;
      n = (l == 0) ? 1 : ((int'(l) > MAXL) ? MAXL : int'(l));
      for (int k = 0; k < LANES; k++) begin
         round_t r;
         r.s   = '0;
         r.lat = n * (3 + SHOW + GAP) + 1;
         for (int i = 0; i < n; i++) begin
            logic [4:0] a;
            a = 5'((int'(base[k]) + i) % 32);
            q_addr[k].push_back(a);
            q_dig[k].push_back(mem[a]);
            r.s = r.s | (20'(mem[a]) << (4 * (MAXL - 1 - i)));
         end
         q_round[k].push_back(r);
      end
   endtask

   // Monitor: consumes expectations whenever a DUT presents an event.
   always @(negedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (!rst_q) begin
            check($sformatf("lane%0d reset S_out", k), 32'(s_out[k]), 32'h0);
            check($sformatf("lane%0d reset digit_out", k), 32'(digit_out[k]), 32'h0);
            check($sformatf("lane%0d reset outputs", k),
                  {26'd0, dvalid[k], busy[k], done[k], ram_r[k], 2'b00}, 32'h0);
            check($sformatf("lane%0d reset RAM_addr", k), 32'(ram_addr[k]), 32'h0);
            q_addr[k].delete();
            q_dig[k].delete();
            q_round[k].delete();
            prev_valid[k] = 1'b0;
            prev_busy[k]  = 1'b0;
            vcnt[k]       = 0;
         end else begin
            if (ram_r[k]) begin
               if (q_addr[k].size() == 0) unexpected($sformatf("lane%0d RAM_r", k));
               else check($sformatf("lane%0d RAM_addr", k), 32'(ram_addr[k]),
                          32'(q_addr[k].pop_front()));
            end
            if (dvalid[k]) begin
               if (!prev_valid[k]) begin
                  vcnt[k] = 1;
                  if (q_dig[k].size() == 0) unexpected($sformatf("lane%0d digit_valid", k));
                  else check($sformatf("lane%0d digit_out", k), 32'(digit_out[k]),
                             32'(q_dig[k].pop_front()));
               end else begin
                  vcnt[k]++;
               end
            end else if (prev_valid[k]) begin
               check($sformatf("lane%0d hold length", k), 32'(vcnt[k]), 32'(SHOW));
               check($sformatf("lane%0d digit blank", k), 32'(digit_out[k]), 32'h0);
            end
            if (busy[k] && !prev_busy[k]) acc_cyc[k] = cyc;
            if (done[k]) begin
               if (q_round[k].size() == 0) unexpected($sformatf("lane%0d display_done", k));
               else begin
                  round_t r;
                  r = q_round[k].pop_front();
                  check($sformatf("lane%0d S_out", k), 32'(s_out[k]), 32'(r.s));
                  check($sformatf("lane%0d done latency", k), 32'(cyc - acc_cyc[k] + 1), 32'(r.lat));
                  check($sformatf("lane%0d busy at done", k), 32'(busy[k]), 32'h1);
               end
            end
            prev_valid[k] = dvalid[k];
            prev_busy[k]  = busy[k];
         end
      end
   end

   // One round: optional start re-pulse mid-round and a start in the DONE cycle,
   // both of which must be ignored.
   task automatic run_round(input logic [2:0] l, input bit repulse, input bit done_start);
      int n;
      n = (l == 0) ? 1 : ((int'(l) > MAXL) ? MAXL : int'(l));
      expect_round(l);
      start = 1'b1;
      lvl   = l;
      @(posedge clk); #1;
      start = 1'b0;
      lvl   = 3'($urandom);
      for (int c = 0; c < n * (3 + SHOW + GAP); c++) begin
         if (repulse && c == n * 4) begin
            start = 1'b1;
            lvl   = 3'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = done_start;
      lvl   = 3'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      repeat ($urandom_range(1, 3)) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      lvl   = '0;
      base[0] = 5'd0;
      base[1] = 5'd30;
      for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
      mem[0] = 4'h1;
      mem[1] = 4'h2;
      mem[2] = 4'h3;
      mem[3] = 4'hA;
      mem[4] = 4'hC;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      run_round(3'd5, 1'b0, 1'b0);
      run_round(3'd2, 1'b0, 1'b0);
      run_round(3'd0, 1'b0, 1'b0);
      run_round(3'd7, 1'b0, 1'b0);
      run_round(3'd4, 1'b0, 1'b0);
      run_round(3'd5, 1'b1, 1'b1);

      // Abort during the hold window of the second digit.
      expect_round(3'd5);
      start = 1'b1;
      lvl   = 3'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      run_round(3'd3, 1'b0, 1'b0);

      for (int r = 0; r < 10; r++)
         run_round(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (5) @(posedge clk);
      for (int k = 0; k < LANES; k++) begin
         check($sformatf("lane%0d reads outstanding", k), 32'(q_addr[k].size()), 32'h0);
         check($sformatf("lane%0d digits outstanding", k), 32'(q_dig[k].size()), 32'h0);
         check($sformatf("lane%0d rounds outstanding", k), 32'(q_round[k].size()), 32'h0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
